// File: rtl/multi_cycle_control_if.sv
// Control-unit bundle: instruction fields and flags in, datapath controls and status out.
interface multi_cycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             step;
    logic             Pcwre;
    logic             IRwre;
    logic             Regwre;
    logic             Memwre;
    logic             Memread;
    logic             ALUsrc;
    logic             RegDst;
    logic             MemtoReg;
    logic [1:0]       PCSrc;
    logic [4:0]       ALUOp;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired;
    logic             illegal;
    logic             halted;

    modport master (
        output op, func, zero, step,
        input  Pcwre, IRwre, Regwre, Memwre, Memread, ALUsrc, RegDst, MemtoReg,
        input  PCSrc, ALUOp, state, retire, retired, illegal, halted
    );

    modport slave (
        input  op, func, zero, step,
        output Pcwre, IRwre, Regwre, Memwre, Memread, ALUsrc, RegDst, MemtoReg,
        output PCSrc, ALUOp, state, retire, retired, illegal, halted
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with retired-instruction counter.
// Optional macro STEP_MODE_EN makes IF wait for a step request.
module multi_cycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    multi_cycle_control_if.slave bus
);

    typedef enum logic [2:0] {
        StIf   = 3'd0,
        StId   = 3'd1,
        StExe  = 3'd2,
        StMem  = 3'd3,
        StWb   = 3'd4,
        StHalt = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        InsAdd, InsSub, InsAnd, InsOr, InsSlt, InsSll,
        InsAddi, InsOri, InsLw, InsSw, InsBeq, InsJ, InsHalt, InsIll
    } ins_e;

    function automatic ins_e decode(input logic [5:0] o, input logic [5:0] f);
        ins_e r;
        r = InsIll;
        case (o)
            6'b000000: begin
                case (f)
                    6'b100000: r = InsAdd;
                    6'b100010: r = InsSub;
                    6'b100100: r = InsAnd;
                    6'b100101: r = InsOr;
                    6'b101010: r = InsSlt;
                    6'b000000: r = InsSll;
                    default:   r = InsIll;
                endcase
            end
            6'b001000: r = InsAddi;
            6'b001101: r = InsOri;
            6'b100011: r = InsLw;
            6'b101011: r = InsSw;
            6'b000100: r = InsBeq;
            6'b000010: r = InsJ;
            6'b111111: r = InsHalt;
            default:   r = InsIll;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] alu_of(input ins_e i);
        logic [4:0] a;
        case (i)
            InsSub, InsBeq: a = 5'd1;
            InsAnd:         a = 5'd2;
            InsOr, InsOri:  a = 5'd3;
            InsSlt:         a = 5'd4;
            InsSll:         a = 5'd5;
            default:        a = 5'd0;
        endcase
        return a;
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       op_q, func_q;
    logic [CNT_W-1:0] retired_q;
    ins_e             ins_id, ins_q;
    logic             is_r_q;

    logic       pcwre, irwre, regwre, memwre, memread, alusrc, regdst, memtoreg;
    logic       retire, illegal, halted;
    logic [1:0] pcsrc;
    logic [4:0] aluop;

    // ID decodes the live fields it is about to latch; later states see only the copy.
    assign ins_id = decode(bus.op, bus.func);
    assign ins_q  = decode(op_q, func_q);
    assign is_r_q = (op_q == 6'b000000);

    always_comb begin
        state_d  = state_q;
        pcwre    = 1'b0;
        irwre    = 1'b0;
        regwre   = 1'b0;
        memwre   = 1'b0;
        memread  = 1'b0;
        alusrc   = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcsrc    = 2'b00;
        aluop    = 5'd0;
        retire   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (state_q)
            StIf: begin
`ifdef STEP_MODE_EN
                if (bus.step) begin
                    irwre   = 1'b1;
                    pcwre   = 1'b1;
                    state_d = StId;
                end
`else
                irwre   = 1'b1;
                pcwre   = 1'b1;
                state_d = StId;
`endif
            end
            StId: begin
                case (ins_id)
                    InsJ: begin
                        pcwre   = 1'b1;
                        pcsrc   = 2'b10;
                        retire  = 1'b1;
                        state_d = StIf;
                    end
                    InsHalt: begin
                        retire  = 1'b1;
                        state_d = StHalt;
                    end
                    InsIll: begin
                        illegal = 1'b1;
                        state_d = StIf;
                    end
                    default: state_d = StExe;
                endcase
            end
            StExe: begin
                aluop  = alu_of(ins_q);
                alusrc = (ins_q == InsAddi) || (ins_q == InsOri) ||
                         (ins_q == InsLw)   || (ins_q == InsSw);
                if (ins_q == InsBeq) begin
                    pcwre   = bus.zero;
                    pcsrc   = 2'b01;
                    retire  = 1'b1;
                    state_d = StIf;
                end else if ((ins_q == InsLw) || (ins_q == InsSw)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (ins_q == InsLw) begin
                    memread = 1'b1;
                    state_d = StWb;
                end else begin
                    memwre  = (ins_q == InsSw);
                    retire  = (ins_q == InsSw);
                    state_d = StIf;
                end
            end
            StWb: begin
                regwre   = 1'b1;
                regdst   = is_r_q;
                memtoreg = (ins_q == InsLw);
                retire   = 1'b1;
                state_d  = StIf;
            end
            StHalt: halted = 1'b1;
            default: state_d = StIf;
        endcase
        // Reset masks every side effect so an abandoned instruction leaves no trace.
        if (reset) begin
            pcwre   = 1'b0;
            irwre   = 1'b0;
            regwre  = 1'b0;
            memwre  = 1'b0;
            memread = 1'b0;
            retire  = 1'b0;
            illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIf;
            op_q      <= 6'd0;
            func_q    <= 6'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StId) begin
                op_q   <= bus.op;
                func_q <= bus.func;
            end
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

`ifndef STEP_MODE_EN
    logic unused_step;
    assign unused_step = bus.step;
`endif

    assign bus.Pcwre    = pcwre;
    assign bus.IRwre    = irwre;
    assign bus.Regwre   = regwre;
    assign bus.Memwre   = memwre;
    assign bus.Memread  = memread;
    assign bus.ALUsrc   = alusrc;
    assign bus.RegDst   = regdst;
    assign bus.MemtoReg = memtoreg;
    assign bus.PCSrc    = pcsrc;
    assign bus.ALUOp    = aluop;
    assign bus.state    = state_q;
    assign bus.retire   = retire;
    assign bus.retired  = retired_q;
    assign bus.illegal  = illegal;
    assign bus.halted   = halted;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized self-checking bench for multi_cycle_control against an instruction-level model.
module tb_multi_cycle_control;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, regwre, memwre, memread, alusrc, regdst, memtoreg;
        logic [1:0] pcsrc;
        logic [4:0] aluop;
        logic       retire, illegal, halted;
    } obs_t;

    localparam int K_R = 0, K_ADDI = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6;
    localparam int K_HALT = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [CNT_W-1:0] cnt = '0;
    obs_t exp_q[$];

    logic [5:0] t_op[12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] t_fn[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    multi_cycle_control_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.st = bus.state;
        o.pcwre = bus.Pcwre;
        o.irwre = bus.IRwre;
        o.regwre = bus.Regwre;
        o.memwre = bus.Memwre;
        o.memread = bus.Memread;
        o.alusrc = bus.ALUsrc;
        o.regdst = bus.RegDst;
        o.memtoreg = bus.MemtoReg;
        o.pcsrc = bus.PCSrc;
        o.aluop = bus.ALUOp;
        o.retire = bus.retire;
        o.illegal = bus.illegal;
        o.halted = bus.halted;
        return o;
    endfunction

    // Instruction class and ALU operation straight from the opcode tables.
    function automatic int classify(input logic [5:0] o, input logic [5:0] f, output int alu);
        alu = 0;
        if (o == 6'h00) begin
            if (f == 6'h20) begin alu = 0; return K_R; end
            if (f == 6'h22) begin alu = 1; return K_R; end
            if (f == 6'h24) begin alu = 2; return K_R; end
            if (f == 6'h25) begin alu = 3; return K_R; end
            if (f == 6'h2A) begin alu = 4; return K_R; end
            if (f == 6'h00) begin alu = 5; return K_R; end
            return K_ILL;
        end
        if (o == 6'h08) return K_ADDI;
        if (o == 6'h0D) begin alu = 3; return K_ORI; end
        if (o == 6'h23) return K_LW;
        if (o == 6'h2B) return K_SW;
        if (o == 6'h04) begin alu = 1; return K_BEQ; end
        if (o == 6'h02) return K_J;
        if (o == 6'h3F) return K_HALT;
        return K_ILL;
    endfunction

    // Expected per-cycle outputs of one instruction, IF up to the cycle before the next IF.
    function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z);
        obs_t e;
        int alu;
        int k;
        k = classify(o, f, alu);
        exp_q.delete();
        e = '0; e.st = 3'd0; e.pcwre = 1'b1; e.irwre = 1'b1;
        exp_q.push_back(e);
        e = '0; e.st = 3'd1;
        if (k == K_ILL) begin e.illegal = 1'b1; exp_q.push_back(e); return; end
        if (k == K_HALT) begin e.retire = 1'b1; exp_q.push_back(e); return; end
        if (k == K_J) begin
            e.pcwre = 1'b1; e.pcsrc = 2'b10; e.retire = 1'b1;
            exp_q.push_back(e);
            return;
        end
        exp_q.push_back(e);
        e = '0; e.st = 3'd2; e.aluop = 5'(alu);
        e.alusrc = (k == K_ADDI || k == K_ORI || k == K_LW || k == K_SW);
        if (k == K_BEQ) begin
            e.pcwre = z; e.pcsrc = 2'b01; e.retire = 1'b1;
            exp_q.push_back(e);
            return;
        end
        exp_q.push_back(e);
        if (k == K_LW || k == K_SW) begin
            e = '0; e.st = 3'd3;
            if (k == K_SW) begin
                e.memwre = 1'b1; e.retire = 1'b1;
                exp_q.push_back(e);
                return;
            end
            e.memread = 1'b1;
            exp_q.push_back(e);
        end
        e = '0; e.st = 3'd4; e.regwre = 1'b1; e.regdst = (k == K_R);
        e.memtoreg = (k == K_LW); e.retire = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Starts just after the edge that entered IF; ends just after the edge back into IF.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input string nm);
        model(o, f, z);
        bus.op = o;
        bus.func = f;
        bus.zero = z;
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", nm, i), 32'(observe()), 32'(exp_q[i]));
            if (exp_q[i].retire) cnt = cnt + 1'b1;
            @(posedge clk);
            #1;
            if (i >= 1) begin
                bus.op = 6'($urandom);
                bus.func = 6'($urandom);
            end
        end
        check($sformatf("%s retired", nm), 32'(bus.retired), 32'(cnt));
    endtask

    initial begin
        obs_t idle;
        int   idx;
        logic [5:0] ro, rf;
        bus.op = 6'h00;
        bus.func = 6'h00;
        bus.zero = 1'b0;
`ifdef STEP_MODE_EN
        bus.step = 1'b0;
`else
        bus.step = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle = '0;
        check("reset outputs", 32'(observe()), 32'(idle));
        check("reset retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef STEP_MODE_EN
        repeat (10) begin
            @(negedge clk);
            check("step hold", 32'(observe()), 32'(idle));
        end
        @(posedge clk);
        #1 bus.step = 1'b1;
`endif

        run_instr(6'h00, 6'h20, 1'b0, "add");
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h2B, 6'h00, 1'b0, "sw");
        run_instr(6'h04, 6'h00, 1'b1, "beq_z1");
        run_instr(6'h04, 6'h00, 1'b0, "beq_z0");
        run_instr(6'h15, 6'h00, 1'b0, "illegal_op");
        run_instr(6'h00, 6'h3F, 1'b0, "illegal_func");

        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 12);
            if (idx == 12) begin
                ro = 6'($urandom);
                rf = 6'($urandom);
                if (ro == 6'h3F) ro = 6'h3E;
            end else begin
                ro = t_op[idx];
                rf = t_fn[idx];
            end
            run_instr(ro, rf, 1'($urandom), $sformatf("rnd%0d", n));
        end

        while (cnt != {CNT_W{1'b1}}) run_instr(6'h02, 6'h00, 1'b0, "j_fill");
        run_instr(6'h02, 6'h00, 1'b0, "j_wrap");
        check("wrap to zero", 32'(bus.retired), 32'd0);

        // Abandon a lw in MEM with reset.
        bus.op = 6'h23;
        bus.func = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        check("lw in mem", 32'(bus.state), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        idle = '0;
        idle.st = 3'd3;
        check("mem reset masked", 32'(observe()), 32'(idle));
        @(posedge clk);
        #1 reset = 1'b0;
        cnt = '0;
        check("reset to IF", 32'(bus.state), 32'd0);
        check("reset retired clr", 32'(bus.retired), 32'd0);
        @(negedge clk);
        check("no regwre after", 32'(bus.Regwre), 32'd0);
        @(posedge clk);
        #1;
        check("retired after rst", 32'(bus.retired), 32'd0);
        // The mid-reset IF fetched something; re-align with a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'h3F, 6'h00, 1'b0, "halt");
        idle = '0;
        idle.st = 3'd7;
        idle.halted = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bus.op = 6'($urandom);
            @(negedge clk);
            check($sformatf("halt hold%0d", n), 32'(observe()), 32'(idle));
        end
        check("halt retired", 32'(bus.retired), 32'(cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: op  in  6  opcode field of instruction register.
REQ-005 Port: func  in  6  function field of instruction register.
REQ-006 Port: zero  in  1  ALU zero flag.
REQ-007 Port: step  in  1  single-step request; ignored unless STEP_MODE_EN is defined.
REQ-008 Port outputs, 1 bit each: Pcwre, IRwre, Regwre, Memwre, Memread, ALUsrc, RegDst, MemtoReg; 2 bits: PCSrc; 5 bits: ALUOp.
REQ-009 Port: state  out  3  current FSM state.
REQ-010 Port: retire  out  1  one-cycle pulse when an instruction completes.
REQ-011 Port: retired  out  CNT_W  retired-instruction count.
REQ-012 Port: illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-013 Port: halted  out  1  high while in HALT.

Function
REQ-014 States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=7; codes 5 and 6 unreachable and SHALL recover to IF.
REQ-015 op/func SHALL be latched internally in ID; later states SHALL use the latched copy only.
REQ-016 Decode: R-type op=000000 with func add=100000, sub=100010, and=100100, or=100101, slt=101010, sll=000000; addi=001000; ori=001101; lw=100011; sw=101011; beq=000100; j=000010; halt=111111; anything else is illegal.
REQ-017 ALUOp: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5; addi/lw/sw use ADD, ori uses OR, beq uses SUB.
REQ-018 IF: IRwre=1, Pcwre=1, PCSrc=00 (PC+4); next state is ID.
REQ-019 ID: j -> Pcwre=1, PCSrc=10, retire, next IF; halt -> retire, next HALT; illegal -> illegal=1, next IF, no other write enable; otherwise next EXE.
REQ-020 EXE: ALUsrc=1 for addi/ori/lw/sw, else 0; beq -> Pcwre=zero, PCSrc=01, retire, next IF; lw/sw -> MEM; others -> WB.
REQ-021 MEM: lw -> Memread=1, next WB; sw -> Memwre=1, retire, next IF.
REQ-022 WB: Regwre=1; RegDst=1 for R-type, else 0; MemtoReg=1 for lw, else 0; retire; next IF.
REQ-023 Latency in cycles, IF to next IF: j 2, beq 3, R/addi/ori/sw 4, lw 5; illegal 2.
REQ-024 Outputs SHALL be combinational decodes of state and latched fields; unlisted enables SHALL be 0 in every state.
REQ-025 retired SHALL increment by 1 on each retire pulse and wrap from all-ones to 0.
REQ-026 HALT: all write enables 0, halted=1; exit only via reset.

Reset
REQ-027 While reset=1, all write enables, retire and illegal SHALL be 0.
REQ-028 On the first edge with reset=1, state SHALL become IF, retired 0, and latched op/func 0.
REQ-029 Reset asserted mid-instruction SHALL abandon it without retiring or writing anything.

Configuration
REQ-030 Macro STEP_MODE_EN: when defined, IF SHALL hold with all outputs 0 until step=1, then behave per REQ-018; when undefined, step SHALL be ignored and IF SHALL never stall.
REQ-031 STEP_MODE_EN SHALL NOT change encodings, latencies after IF, or reset behaviour.

Verification
REQ-032 After reset, run add (op 000000, func 100000) -> states 0,1,2,4,0; Regwre=1 and RegDst=1 only in WB; retired=1.
REQ-033 lw then sw -> lw takes 5 cycles with Memread=1 in MEM and MemtoReg=1 in WB; sw takes 4 cycles with Memwre=1 in MEM; retired=2.
REQ-034 beq with zero=1, then with zero=0 -> EXE has PCSrc=01, and Pcwre is 1 and 0 respectively; each takes 3 cycles.
REQ-035 op=010101 -> illegal pulses once in ID, no write enable asserted, retired unchanged; then halt -> halted=1, held for 20 cycles.
REQ-036 Preload retired to all-ones through repeated j instructions (CNT_W=4), then one more j -> retired=0; a reset in the MEM state of lw -> state=IF, no Regwre pulse.
REQ-037 With STEP_MODE_EN defined, hold step=0 for 10 cycles -> state stays 0 with IRwre=0; pulse step -> one instruction executes.
